// File: rtl/uart_cmd_frame_parser.sv
// Assembles HEADER/CODE/P3..P0/CHK command frames from the UART byte stream and strobes accepted commands.
// Define CMD_TIMEOUT_EN to abort a partial frame after TIMEOUT_CYC idle cycles between bytes.
module uart_cmd_frame_parser #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        cmd_vaild,
    output logic [7:0]  cmd_code,
    output logic [31:0] para_list,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > (1 << 20))) begin : g_timeout_range
        $error("TIMEOUT_CYC must lie in [2, 2**20]");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CODE,
        S_PARA,
        S_CHK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  code_sh_q, code_sh_d;
    logic [31:0] para_sh_q, para_sh_d;
    logic [7:0]  sum_q, sum_d;
    logic        cmd_vaild_q, cmd_vaild_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic [31:0] para_list_q, para_list_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        busy_q, busy_d;
    logic        err_inc;
    logic        code_ok;

`ifdef CMD_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);
    logic [19:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign code_ok = (code_sh_q inside {8'hA0, 8'hA1, 8'hA2});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        code_sh_d   = code_sh_q;
        para_sh_d   = para_sh_q;
        sum_d       = sum_q;
        cmd_vaild_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        para_list_d = para_list_q;
        err_cnt_d   = err_cnt_q;
        err_inc     = 1'b0;
`ifdef CMD_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        // A HEADER byte seen after IDLE is ordinary frame data; no mid-frame resync.
        case (state_q)
            S_IDLE: begin
                if (rx_done && (rx_data == HEADER)) begin
                    state_d = S_CODE;
                    sum_d   = '0;
                end
            end
            S_CODE: begin
                if (rx_done) begin
                    code_sh_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    idx_d     = '0;
                    state_d   = S_PARA;
                end
            end
            S_PARA: begin
                if (rx_done) begin
                    para_sh_d = {para_sh_q[23:0], rx_data};
                    sum_d     = sum_q + rx_data;
                    if (idx_q == 2'd3) begin
                        state_d = S_CHK;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_CHK: begin
                if (rx_done) begin
                    state_d = S_IDLE;
                    if ((rx_data == sum_q) && code_ok) begin
                        cmd_vaild_d = 1'b1;
                        cmd_code_d  = code_sh_q;
                        para_list_d = para_sh_q;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // A byte arriving on the expiry cycle clears the counter, so it takes precedence.
        if ((state_q == S_IDLE) || rx_done) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_d = '0;
            state_d   = S_IDLE;
            code_sh_d = '0;
            para_sh_d = '0;
            err_inc   = 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 20'd1;
        end
`endif

        frame_err_d = err_inc;
        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            code_sh_q   <= '0;
            para_sh_q   <= '0;
            sum_q       <= '0;
            cmd_vaild_q <= 1'b0;
            cmd_code_q  <= '0;
            para_list_q <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_sh_q   <= code_sh_d;
            para_sh_q   <= para_sh_d;
            sum_q       <= sum_d;
            cmd_vaild_q <= cmd_vaild_d;
            cmd_code_q  <= cmd_code_d;
            para_list_q <= para_list_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign cmd_vaild = cmd_vaild_q;
    assign cmd_code  = cmd_code_q;
    assign para_list = para_list_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed bench for uart_cmd_frame_parser; timeout expectations follow CMD_TIMEOUT_EN.
module tb_uart_cmd_frame_parser;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        cmd_vaild;
    logic [7:0]  cmd_code;
    logic [31:0] para_list;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    int n_assert = 0;
    int n_fail = 0;
    int vld_pulses = 0;
    int err_pulses = 0;
    int e0;
    logic [7:0]  exp_code = 8'h00;
    logic [7:0]  exp_err = 8'h00;
    logic [31:0] exp_para = 32'h0;

    uart_cmd_frame_parser #(
        .HEADER(8'hAA),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .cmd_vaild(cmd_vaild),
        .cmd_code(cmd_code),
        .para_list(para_list),
        .frame_err(frame_err),
        .err_cnt(err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (cmd_vaild === 1'b1) vld_pulses++;
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vaild"}, {31'd0, cmd_vaild}, 32'd0);
        check({tag, "_code"}, {24'd0, cmd_code}, 32'd0);
        check({tag, "_para"}, para_list, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_errcnt"}, {24'd0, err_cnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Sends a full frame back-to-back and checks the strobe in the cycle after CHK.
    task automatic send_frame(input string tag, input logic [7:0] code, input logic [31:0] p,
                              input logic [7:0] chk, input bit ok);
        send_byte(8'hAA);
        send_byte(code);
        send_byte(p[31:24]);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
        send_byte(chk);
        if (ok) begin
            exp_code = code;
            exp_para = p;
        end else if (exp_err != 8'hFF) begin
            exp_err = exp_err + 8'd1;
        end
        check({tag, "_vaild"}, {31'd0, cmd_vaild}, {31'd0, ok});
        check({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, !ok});
        check({tag, "_code"}, {24'd0, cmd_code}, {24'd0, exp_code});
        check({tag, "_para"}, para_list, exp_para);
        check({tag, "_errcnt"}, {24'd0, err_cnt}, {24'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;
        @(negedge clk);

        send_frame("valid", 8'hA1, 32'h00FF00FF, 8'h9F, 1'b1);
        @(negedge clk);
        check("valid_vaild_drop", {31'd0, cmd_vaild}, 32'd0);
        check("valid_no_err", err_pulses, 0);

        repeat (2) @(negedge clk);
        send_frame("badchk", 8'hA0, 32'h00000010, 8'h11, 1'b0);
        @(negedge clk);
        check("badchk_ferr_drop", {31'd0, frame_err}, 32'd0);

        send_frame("illegal", 8'hB3, 32'h00000000, 8'hB3, 1'b0);
        check("illegal_no_vaild", vld_pulses, 1);

        send_byte(8'h12);
        send_byte(8'h34);
        check("noise_busy", {31'd0, busy}, 32'd0);
        send_frame("noise_frame", 8'hA2, 32'h00000005, 8'hA7, 1'b1);
        send_frame("b2b_frame", 8'hA0, 32'h12345678, 8'hB4, 1'b1);
        check("b2b_vaild_total", vld_pulses, 3);
        check("b2b_err_total", err_pulses, 2);

        @(negedge clk);
        send_byte(8'hAA);
        send_byte(8'hA0);
        send_byte(8'h01);
        e0 = err_pulses;
        repeat (TO - 1) @(negedge clk);
        check("stall_pre_busy", {31'd0, busy}, 32'd1);
        check("stall_pre_ferr", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        exp_err = exp_err + 8'd1;
        check("timeout_ferr", {31'd0, frame_err}, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_errcnt", {24'd0, err_cnt}, {24'd0, exp_err});
        check("timeout_pulses", err_pulses, e0 + 1);
        @(negedge clk);
        check("timeout_ferr_drop", {31'd0, frame_err}, 32'd0);
        send_frame("after_timeout", 8'hA1, 32'h00000000, 8'hA1, 1'b1);
`else
        repeat (4) @(negedge clk);
        check("no_timeout_ferr", err_pulses, e0);
        check("no_timeout_busy", {31'd0, busy}, 32'd1);
        check("no_timeout_errcnt", {24'd0, err_cnt}, {24'd0, exp_err});
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_code = 8'h00;
        exp_para = 32'h0;
        exp_err  = 8'h00;
        @(negedge clk);
`endif

        send_byte(8'hAA);
        send_byte(8'hA1);
        send_byte(8'h00);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_code = 8'h00;
        exp_para = 32'h0;
        exp_err  = 8'h00;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_frame("post_reset", 8'hA1, 32'h00FF00FF, 8'h9F, 1'b1);

        for (int i = 0; i < 260; i++) begin
            send_frame("sat", 8'hA0, 32'h00000000, 8'h01, 1'b0);
        end
        check("sat_errcnt", {24'd0, err_cnt}, 32'h000000FF);
        check("sat_code_kept", {24'd0, cmd_code}, 32'h000000A1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
